// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//
// Fetch-side branch prediction controller for a 5-stage RV32I pipeline.
//  - Combinational next-PC prediction from the BTB hit/target and a table of
//    2-bit saturating counters (BHT), indexed by PC[BHT_ADDR_LEN+1:2].
//  - Each prediction is carried through IF/ID and ID/EX and checked against
//    the EX-stage outcome. A mispredict redirects fetch and squashes both
//    younger stages.
//  - The BHT is trained at resolution. BTB writes (install or alias
//    eviction) are registered and issued one cycle after resolution.
//
// Optional feature macro: BRANCH_STATS_EN
//   When defined, this adds the stat_branches / stat_mispredicts ports,
//   which are 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
    parameter int BHT_ADDR_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,

    // IF stage: BTB lookup result and prediction
    input  logic [31:0] if_PC,
    input  logic        if_btb_hit,
    input  logic [31:0] if_btb_target,
    output logic        if_pred_taken,
    output logic [31:0] if_npc,

    // Hazard unit
    input  logic        stall,

    // EX stage resolution
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        redirect,
    output logic [31:0] redirect_PC,

    // Registered BTB write port
    output logic        btb_wr_req,
    output logic [31:0] btb_wr_PC,
    output logic [31:0] btb_wr_target,
    output logic        btb_wr_state
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int BHT_ENTRIES = 1 << BHT_ADDR_LEN;

    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_WEAK_NT = 2'b01;
    localparam ctr_t CTR_MAX     = 2'b11;
    localparam ctr_t CTR_MIN     = 2'b00;

    // Prediction record carried down the pipeline with each fetched PC.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        hit;
        logic        pred_taken;
        logic [31:0] pred_target;
    } pipe_rec_t;

    typedef struct packed {
        logic        req;
        logic [31:0] pc;
        logic [31:0] target;
        logic        state;
    } btb_wr_t;

    pipe_rec_t ifid_q, ifid_d;
    pipe_rec_t idex_q, idex_d;
    btb_wr_t   btb_wr_q, btb_wr_d;
    ctr_t      bht_q [BHT_ENTRIES];
    ctr_t      bht_d [BHT_ENTRIES];

    logic [BHT_ADDR_LEN-1:0] if_idx;
    logic [BHT_ADDR_LEN-1:0] ex_idx;
    logic [31:0]             ex_pc_plus4;
    logic                    mispredict;

    // Predict the next fetch PC from the BTB and the current BHT contents.
    // The BHT is read before this cycle's update lands, so an entry that is
    // being trained in this cycle still returns its old counter.
    always_comb begin
        if_idx        = if_PC[BHT_ADDR_LEN+1:2];
        if_pred_taken = if_btb_hit & bht_q[if_idx][1];
        if_npc        = if_pred_taken ? if_btb_target : if_PC + 32'd4;
    end

    // Resolve the EX-stage prediction and form the fetch redirect.
    // NOTE: every combinational output gets a default before any branch of
    // the logic, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        ex_pc_plus4 = idex_q.pc + 32'd4;
        mispredict  = 1'b0;
        redirect_PC = 32'd0;
        if (idex_q.valid) begin
            if (ex_is_branch) begin
                if (ex_taken != idex_q.pred_taken) begin
                    mispredict = 1'b1;
                end else if (ex_taken && idex_q.pred_taken &&
                             (ex_target != idex_q.pred_target)) begin
                    mispredict = 1'b1;
                end
            end else if (idex_q.pred_taken) begin
                // A BTB hit on a non-branch is an alias, and fetch went astray.
                mispredict = 1'b1;
            end
        end
        if (mispredict) begin
            redirect_PC = (ex_is_branch && ex_taken) ? ex_target : ex_pc_plus4;
        end
        redirect = mispredict;
    end

    // Advance the IF/ID and ID/EX records. A redirect squashes both stages
    // and takes priority over a load-use stall.
    always_comb begin
        ifid_d = ifid_q;
        idex_d = ifid_q;
        if (mispredict) begin
            ifid_d = '0;
            idex_d = '0;
        end else if (stall) begin
            ifid_d = ifid_q;
            idex_d = '0;
        end else begin
            ifid_d.valid       = 1'b1;
            ifid_d.pc          = if_PC;
            ifid_d.hit         = if_btb_hit;
            ifid_d.pred_taken  = if_pred_taken;
            ifid_d.pred_target = if_btb_target;
        end
    end

    // Train the 2-bit counter of a resolved branch, saturating at both ends.
    always_comb begin
        bht_d  = bht_q;
        ex_idx = idex_q.pc[BHT_ADDR_LEN+1:2];
        if (idex_q.valid && ex_is_branch) begin
            if (ex_taken) begin
                if (bht_q[ex_idx] != CTR_MAX) begin
                    bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
                end
            end else begin
                if (bht_q[ex_idx] != CTR_MIN) begin
                    bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
                end
            end
        end
    end

    // Decide the BTB write for the resolving instruction. It is either an
    // install or retarget of a taken branch, or the eviction of an alias
    // that hit on a non-branch.
    always_comb begin
        btb_wr_d = '0;
        if (idex_q.valid) begin
            if (ex_is_branch && ex_taken &&
                (!idex_q.hit || (idex_q.pred_target != ex_target))) begin
                btb_wr_d.req    = 1'b1;
                btb_wr_d.pc     = idex_q.pc;
                btb_wr_d.target = ex_target;
                btb_wr_d.state  = 1'b1;
            end else if (!ex_is_branch && idex_q.hit) begin
                btb_wr_d.req    = 1'b1;
                btb_wr_d.pc     = idex_q.pc;
                btb_wr_d.target = 32'd0;
                btb_wr_d.state  = 1'b0;
            end
        end
    end

    // Pipeline records and the registered BTB write port.
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of the others, whatever order the blocks are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q   <= '0;
            idex_q   <= '0;
            btb_wr_q <= '0;
        end else begin
            ifid_q   <= ifid_d;
            idex_q   <= idex_d;
            btb_wr_q <= btb_wr_d;
        end
    end

    // Counter table. It restarts weakly not-taken after every reset.
    // NOTE: the table is built from flops rather than a RAM macro, so a full
    // reset loop is legal here and gives the table a known reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_WEAK_NT;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    assign btb_wr_req    = btb_wr_q.req;
    assign btb_wr_PC     = btb_wr_q.pc;
    assign btb_wr_target = btb_wr_q.target;
    assign btb_wr_state  = btb_wr_q.state;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Count resolved branches and redirects. Both counters wrap.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (idex_q.valid && ex_is_branch) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mispredict) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
//
// Self-checking bench for branch_predict_ctrl. A table of fetches is played
// into IF, one per cycle. Each entry carries hand-derived expected
// prediction and resolution values. When an entry is driven into EX, its
// expected redirect and BTB write are pushed to scoreboard queues. These are
// popped and compared when the DUT produces them: the redirect in the same
// cycle and the BTB write one cycle later. The table ends with an
// asynchronous reset applied mid-operation.
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_PC;
    logic        if_btb_hit;
    logic [31:0] if_btb_target;
    logic        if_pred_taken;
    logic [31:0] if_npc;
    logic        stall;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        redirect;
    logic [31:0] redirect_PC;
    logic        btb_wr_req;
    logic [31:0] btb_wr_PC;
    logic [31:0] btb_wr_target;
    logic        btb_wr_state;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predict_ctrl #(.BHT_ADDR_LEN(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_PC         (if_PC),
        .if_btb_hit    (if_btb_hit),
        .if_btb_target (if_btb_target),
        .if_pred_taken (if_pred_taken),
        .if_npc        (if_npc),
        .stall         (stall),
        .ex_is_branch  (ex_is_branch),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .redirect      (redirect),
        .redirect_PC   (redirect_PC),
        .btb_wr_req    (btb_wr_req),
        .btb_wr_PC     (btb_wr_PC),
        .btb_wr_target (btb_wr_target),
        .btb_wr_state  (btb_wr_state)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // One fetched instruction: IF stimulus, its expected prediction, and its
    // EX outcome with the expected redirect and BTB write.
    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] btgt;
        logic        stall;
        logic        exp_pred;
        logic [31:0] exp_npc;
        logic        is_br;
        logic        taken;
        logic [31:0] tgt;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_wr;
        logic [31:0] exp_wr_pc;
        logic [31:0] exp_wr_tgt;
        logic        exp_wr_state;
    } op_t;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
    } res_exp_t;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        state;
    } wr_exp_t;

    op_t      prog [$];
    res_exp_t res_q [$];
    wr_exp_t  wr_q [$];
    int       n_checks = 0;
    int       n_errors = 0;
    int       id_s;
    int       ex_s;
    op_t      cur;
    res_exp_t r_exp;
    wr_exp_t  w_exp;
    wr_exp_t  w_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic op_t filler(input logic [31:0] pc);
        op_t o;
        o = '{pc: pc, hit: 1'b0, btgt: 32'd0, stall: 1'b0, exp_pred: 1'b0,
              exp_npc: pc + 32'd4, is_br: 1'b0, taken: 1'b0, tgt: 32'd0,
              exp_redir: 1'b0, exp_rpc: 32'd0, exp_wr: 1'b0, exp_wr_pc: 32'd0,
              exp_wr_tgt: 32'd0, exp_wr_state: 1'b0};
        return o;
    endfunction

    function automatic op_t mk(
        input logic [31:0] pc, input logic hit, input logic [31:0] btgt,
        input logic exp_pred, input logic [31:0] exp_npc,
        input logic is_br, input logic taken, input logic [31:0] tgt,
        input logic exp_redir, input logic [31:0] exp_rpc,
        input logic exp_wr, input logic [31:0] wr_pc, input logic [31:0] wr_tgt,
        input logic wr_state);
        op_t o;
        o = '{pc: pc, hit: hit, btgt: btgt, stall: 1'b0, exp_pred: exp_pred,
              exp_npc: exp_npc, is_br: is_br, taken: taken, tgt: tgt,
              exp_redir: exp_redir, exp_rpc: exp_rpc, exp_wr: exp_wr,
              exp_wr_pc: wr_pc, exp_wr_tgt: wr_tgt, exp_wr_state: wr_state};
        return o;
    endfunction

    function automatic op_t stalled(input op_t o);
        op_t s;
        s       = o;
        s.stall = 1'b1;
        return s;
    endfunction

    // Watchdog: the bench is cycle-bounded, but never let it hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Program. Comments give the BHT[0x80] counter (PC 0x200/0x600/0xA00)
        // seen at IF for the entries that depend on it.
        prog.push_back(filler(32'h100));                                   // c0 reset, no hit
        prog.push_back(mk(32'h200, 0, 0, 0, 32'h204, 1, 1, 32'h180,
                          1, 32'h180, 1, 32'h200, 32'h180, 1));            // c1 cold taken
        prog.push_back(filler(32'h204));                                   // c2 squashed
        prog.push_back(filler(32'h208));                                   // c3 lost
        prog.push_back(mk(32'h200, 1, 32'h180, 1, 32'h180, 1, 1, 32'h180,
                          0, 0, 0, 0, 0, 0));                              // c4 warm, ctr 10
        prog.push_back(filler(32'h180));                                   // c5
        prog.push_back(mk(32'h200, 1, 32'h180, 1, 32'h180, 1, 0, 32'h180,
                          1, 32'h204, 0, 0, 0, 0));                        // c6 ctr 10 (no bypass), resolves at 11
        prog.push_back(filler(32'h180));                                   // c7 squashed
        prog.push_back(filler(32'h184));                                   // c8 lost
        prog.push_back(mk(32'h600, 1, 32'h500, 1, 32'h500, 0, 0, 32'h0,
                          1, 32'h604, 1, 32'h600, 32'h0, 0));              // c9 alias, ctr 10
        prog.push_back(filler(32'h500));                                   // c10 squashed
        prog.push_back(filler(32'h504));                                   // c11 lost
        prog.push_back(mk(32'h200, 1, 32'h180, 1, 32'h180, 1, 0, 32'h180,
                          1, 32'h204, 0, 0, 0, 0));                        // c12 ctr 10, stalled in ID
        prog.push_back(stalled(filler(32'h180)));                          // c13 stall
        prog.push_back(stalled(filler(32'h180)));                          // c14 stall
        prog.push_back(mk(32'hA00, 1, 32'h700, 1, 32'h700, 0, 0, 32'h0,
                          1, 32'hA04, 1, 32'hA00, 32'h0, 0));              // c15 must be squashed
        prog.push_back(stalled(filler(32'h700)));                          // c16 stall with redirect
        prog.push_back(mk(32'h200, 1, 32'h180, 0, 32'h204, 1, 1, 32'h180,
                          1, 32'h180, 0, 0, 0, 0));                        // c17 ctr 01
        prog.push_back(filler(32'h204));                                   // c18 squashed
        prog.push_back(filler(32'h208));                                   // c19 lost
        prog.push_back(mk(32'h200, 1, 32'h180, 1, 32'h180, 1, 1, 32'h180,
                          0, 0, 0, 0, 0, 0));                              // c20 ctr 10
        prog.push_back(mk(32'h200, 1, 32'h180, 1, 32'h180, 1, 1, 32'h180,
                          0, 0, 0, 0, 0, 0));                              // c21 ctr 10
        prog.push_back(mk(32'h100, 0, 0, 0, 32'h104, 1, 0, 32'h140,
                          0, 0, 0, 0, 0, 0));                              // c22 idx 0x40: 01->00
        prog.push_back(mk(32'h100, 0, 0, 0, 32'h104, 1, 0, 32'h140,
                          0, 0, 0, 0, 0, 0));                              // c23 idx 0x40: 00->00
        prog.push_back(mk(32'h200, 1, 32'h180, 1, 32'h180, 1, 1, 32'h180,
                          0, 0, 0, 0, 0, 0));                              // c24 ctr 11 (saturated)
        prog.push_back(filler(32'h180));                                   // c25
        prog.push_back(mk(32'h100, 1, 32'h140, 0, 32'h104, 1, 0, 32'h140,
                          0, 0, 0, 0, 0, 0));                              // c26 idx 0x40 at 00
        prog.push_back(mk(32'h200, 1, 32'h190, 1, 32'h190, 1, 1, 32'h180,
                          1, 32'h180, 1, 32'h200, 32'h180, 1));            // c27 stale target
        prog.push_back(filler(32'h190));                                   // c28 squashed
        prog.push_back(filler(32'h194));                                   // c29 lost
        prog.push_back(filler(32'h180));                                   // c30
        prog.push_back(filler(32'h184));                                   // c31
        prog.push_back(filler(32'h188));                                   // c32
        prog.push_back(filler(32'h18C));                                   // c33

        rst           = 1'b1;
        if_PC         = 32'd0;
        if_btb_hit    = 1'b0;
        if_btb_target = 32'd0;
        stall         = 1'b0;
        ex_is_branch  = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = 32'd0;

        @(negedge clk);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_redirect_pc", redirect_PC, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        id_s = -1;
        ex_s = -1;
        // BTB port must be idle in the first cycle after reset.
        wr_q.push_back('{req: 1'b0, pc: 32'd0, tgt: 32'd0, state: 1'b0});

        for (int c = 0; c < prog.size(); c++) begin
            cur           = prog[c];
            if_PC         = cur.pc;
            if_btb_hit    = cur.hit;
            if_btb_target = cur.btgt;
            stall         = cur.stall;
            if (ex_s >= 0) begin
                ex_is_branch = prog[ex_s].is_br;
                ex_taken     = prog[ex_s].taken;
                ex_target    = prog[ex_s].tgt;
                res_q.push_back('{redir: prog[ex_s].exp_redir, rpc: prog[ex_s].exp_rpc});
                w_next = '{req: prog[ex_s].exp_wr, pc: prog[ex_s].exp_wr_pc,
                           tgt: prog[ex_s].exp_wr_tgt, state: prog[ex_s].exp_wr_state};
            end else begin
                ex_is_branch = 1'b0;
                ex_taken     = 1'b0;
                ex_target    = 32'd0;
                res_q.push_back('{redir: 1'b0, rpc: 32'd0});
                w_next = '{req: 1'b0, pc: 32'd0, tgt: 32'd0, state: 1'b0};
            end

            @(negedge clk);
            check($sformatf("c%0d if_pred_taken", c), {31'd0, if_pred_taken}, {31'd0, cur.exp_pred});
            check($sformatf("c%0d if_npc", c), if_npc, cur.exp_npc);
            r_exp = res_q.pop_front();
            check($sformatf("c%0d redirect", c), {31'd0, redirect}, {31'd0, r_exp.redir});
            check($sformatf("c%0d redirect_PC", c), redirect_PC, r_exp.rpc);
            w_exp = wr_q.pop_front();
            check($sformatf("c%0d btb_wr_req", c), {31'd0, btb_wr_req}, {31'd0, w_exp.req});
            if (w_exp.req) begin
                check($sformatf("c%0d btb_wr_PC", c), btb_wr_PC, w_exp.pc);
                check($sformatf("c%0d btb_wr_target", c), btb_wr_target, w_exp.tgt);
                check($sformatf("c%0d btb_wr_state", c), {31'd0, btb_wr_state}, {31'd0, w_exp.state});
            end
            wr_q.push_back(w_next);

            // Track where the table entries sit, using the expected redirect.
            if (ex_s >= 0 && prog[ex_s].exp_redir) begin
                id_s = -1;
                ex_s = -1;
            end else if (cur.stall) begin
                ex_s = -1;
            end else begin
                ex_s = id_s;
                id_s = c;
            end

            @(posedge clk);
            #1;
        end

`ifdef BRANCH_STATS_EN
        check("stat_branches", stat_branches, 32'd12);
        check("stat_mispredicts", stat_mispredicts, 32'd6);
`endif

        // Mid-operation reset: a cold taken branch redirects, and reset then
        // hits before its BTB write is issued.
        if_PC         = 32'h200;
        if_btb_hit    = 1'b0;
        if_btb_target = 32'd0;
        stall         = 1'b0;
        ex_is_branch  = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = 32'd0;
        @(posedge clk);
        #1;
        if_PC = 32'h204;
        @(posedge clk);
        #1;
        if_PC        = 32'h208;
        ex_is_branch = 1'b1;
        ex_taken     = 1'b1;
        ex_target    = 32'h180;
        @(negedge clk);
        check("rst_mid pre redirect", {31'd0, redirect}, 32'd1);
        check("rst_mid pre redirect_PC", redirect_PC, 32'h180);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid redirect", {31'd0, redirect}, 32'd0);
        check("rst_mid redirect_PC", redirect_PC, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid btb_wr_req", {31'd0, btb_wr_req}, 32'd0);
        check("rst_mid btb_wr_PC", btb_wr_PC, 32'd0);
        // The BHT entry for 0x200 was saturated taken and must be back at 01.
        if_PC         = 32'h200;
        if_btb_hit    = 1'b1;
        if_btb_target = 32'h180;
        #1;
        check("rst_mid bht pred", {31'd0, if_pred_taken}, 32'd0);
        check("rst_mid bht npc", if_npc, 32'h204);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst redirect", {31'd0, redirect}, 32'd0);
        check("post_rst btb_wr_req", {31'd0, btb_wr_req}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("post_rst stat_branches", stat_branches, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
